tesla_drive_unit: RTL and testbench



---
 rtl/tesla_drive_unit.sv | 128 ++++++++++++
 tb/tb_tesla_drive_unit.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/tesla_drive_unit.sv
// tesla_drive_unit
// Drive-train stage downstream of the cruise/stop controller. It ramps the
// vehicle speed on a prescaled tick with saturating arithmetic. It also runs a
// door-lock FSM that releases the doors only after the car has been stationary,
// with an unlock request held for UNLOCK_DELAY cycles.
//
// Ports:
//   clk            in   system clock, rising edge
//   rst            in   synchronous active-high reset, overrides all inputs
//   accelerate_car in   ramp speed up on each tick (otherwise ramp down)
//   unlock_doors   in   request door release
//   car_speed      out  8-bit registered vehicle speed
//   door_locked    out  registered, 1 unless the door FSM is OPEN
//   moving         out  combinational car_speed != 0
module tesla_drive_unit #(
  parameter int         TICK_DIV     = 4,
  parameter logic [7:0] ACCEL_STEP   = 8'd2,
  parameter logic [7:0] DECEL_STEP   = 8'd3,
  parameter logic [7:0] MAX_SPEED    = 8'd200,
  parameter int         UNLOCK_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       accelerate_car,
  input  logic       unlock_doors,
  output logic [7:0] car_speed,
  output logic       door_locked,
  output logic       moving
);

  localparam int TCW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int WCW = (UNLOCK_DELAY > 1) ? $clog2(UNLOCK_DELAY) : 1;
  localparam logic [TCW-1:0] TICK_LAST = TCW'(TICK_DIV - 1);
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(UNLOCK_DELAY - 1);

  typedef enum logic [1:0] {
    ST_LOCKED = 2'd0,
    ST_WAIT   = 2'd1,
    ST_OPEN   = 2'd2
  } door_state_e;

  // The sum is widened to 9 bits so a step near the top can never wrap.
  function automatic logic [7:0] sat_add(input logic [7:0] a,
                                         input logic [7:0] b,
                                         input logic [7:0] ceil);
    logic [8:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s > {1'b0, ceil}) return ceil;
    else                  return s[7:0];
  endfunction

  function automatic logic [7:0] sat_sub(input logic [7:0] a,
                                         input logic [7:0] b);
    if (a < b) return 8'd0;
    else       return a - b;
  endfunction

  logic [TCW-1:0] tick_cnt_q, tick_cnt_d;
  logic [7:0]     car_speed_q, car_speed_d;
  logic [WCW-1:0] wait_cnt_q, wait_cnt_d;
  door_state_e    state_q, state_d;
  logic           door_locked_q, door_locked_d;
  logic           tick;
  logic           cond;

  // Prescaler: free-running, independent of the commands.
  always_comb begin
    tick       = (tick_cnt_q == TICK_LAST);
    tick_cnt_d = tick ? '0 : tick_cnt_q + TCW'(1);
  end

  // Speed update only on tick edges.
  always_comb begin
    car_speed_d = car_speed_q;
    if (tick) begin
      if (accelerate_car) car_speed_d = sat_add(car_speed_q, ACCEL_STEP, MAX_SPEED);
      else                car_speed_d = sat_sub(car_speed_q, DECEL_STEP);
    end
  end

  // Door FSM. Acceleration clears cond, so it always wins over an unlock
  // request, and any speed leaving zero drops the FSM back to LOCKED.
  always_comb begin
    cond       = unlock_doors & ~accelerate_car & (car_speed_q == 8'd0);
    state_d    = state_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      ST_LOCKED: begin
        if (cond) begin
          state_d    = ST_WAIT;
          wait_cnt_d = '0;
        end
      end
      ST_WAIT: begin
        if (!cond)                       state_d = ST_LOCKED;
        else if (wait_cnt_q == WAIT_LAST) state_d = ST_OPEN;
        else                             wait_cnt_d = wait_cnt_q + WCW'(1);
      end
      ST_OPEN: begin
        if (!cond) state_d = ST_LOCKED;
      end
      default: state_d = ST_LOCKED;
    endcase
    // Registered Moore output derived from the state being entered.
    door_locked_d = (state_d != ST_OPEN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q    <= '0;
      car_speed_q   <= 8'd0;
      wait_cnt_q    <= '0;
      state_q       <= ST_LOCKED;
      door_locked_q <= 1'b1;
    end else begin
      tick_cnt_q    <= tick_cnt_d;
      car_speed_q   <= car_speed_d;
      wait_cnt_q    <= wait_cnt_d;
      state_q       <= state_d;
      door_locked_q <= door_locked_d;
    end
  end

  assign car_speed   = car_speed_q;
  assign door_locked = door_locked_q;
  assign moving      = (car_speed_q != 8'd0);

endmodule

// File: tb/tb_tesla_drive_unit.sv
// Self-checking bench for tesla_drive_unit. A behavioural model tracks speed
// from "edges since reset" and door state from "consecutive edges with the
// unlock condition"; it is compared against the DUT after every clock edge.
// Directed literal checks at key points pin the model itself.
module tb_tesla_drive_unit;

  localparam int TICK_DIV     = 4;
  localparam int ACCEL        = 2;
  localparam int DECEL        = 3;
  localparam int MAXS         = 200;
  localparam int UNLOCK_DELAY = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       accelerate_car = 1'b0;
  logic       unlock_doors = 1'b0;
  logic [7:0] car_speed;
  logic       door_locked;
  logic       moving;

  int n_checks = 0;
  int n_bad    = 0;

  tesla_drive_unit dut (
    .clk            (clk),
    .rst            (rst),
    .accelerate_car (accelerate_car),
    .unlock_doors   (unlock_doors),
    .car_speed      (car_speed),
    .door_locked    (door_locked),
    .moving         (moving)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model.
  int m_speed  = 0;
  int m_edges  = 0;   // non-reset edges since last reset
  int m_run    = 0;   // consecutive edges sampling the unlock condition
  bit m_valid  = 0;

  always @(posedge clk) begin
    bit c;
    if (rst) begin
      m_speed = 0;
      m_edges = 0;
      m_run   = 0;
      m_valid = 1;
    end else begin
      c = unlock_doors && !accelerate_car && (m_speed == 0);
      m_run = c ? m_run + 1 : 0;
      m_edges++;
      if (m_edges % TICK_DIV == 0) begin
        if (accelerate_car) m_speed = (m_speed + ACCEL > MAXS) ? MAXS : m_speed + ACCEL;
        else                m_speed = (m_speed < DECEL) ? 0 : m_speed - DECEL;
      end
    end
    #1;
    if (m_valid) begin
      chk("model_speed", car_speed, m_speed);
      chk("model_locked", door_locked, (m_run >= UNLOCK_DELAY + 1) ? 0 : 1);
      chk("model_moving", moving, (m_speed != 0) ? 1 : 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset
    cyc(2);
    chk("rst_speed", car_speed, 0);
    chk("rst_locked", door_locked, 1);
    chk("rst_moving", moving, 0);

    // Ramp up: first tick on the 4th edge after release
    rst = 1'b0;
    accelerate_car = 1'b1;
    cyc(3);
    chk("pre_first_tick", car_speed, 0);
    cyc(1);
    chk("first_tick", car_speed, 2);
    chk("moving_on", moving, 1);
    cyc(36);
    chk("ramp_40", car_speed, 20);
    chk("ramp_locked", door_locked, 1);

    // Saturation
    cyc(500);
    chk("saturate", car_speed, 200);

    // Decelerate 200 -> 5 -> 2 -> 0
    accelerate_car = 1'b0;
    cyc(260);
    chk("decel_5", car_speed, 5);
    cyc(4);
    chk("decel_2", car_speed, 2);
    cyc(4);
    chk("decel_0", car_speed, 0);
    cyc(8);
    chk("stay_0", car_speed, 0);
    chk("moving_off", moving, 0);

    // Unlock after dwell, relock on release
    unlock_doors = 1'b1;
    cyc(3);
    chk("dwell_locked", door_locked, 1);
    cyc(1);
    chk("unlocked", door_locked, 0);
    cyc(5);
    chk("stay_open", door_locked, 0);
    unlock_doors = 1'b0;
    cyc(1);
    chk("relock", door_locked, 1);

    // Abort in WAIT
    unlock_doors = 1'b1;
    cyc(2);
    unlock_doors = 1'b0;
    cyc(3);
    chk("abort_wait", door_locked, 1);

    // Open, then accelerate with unlock held: acceleration wins
    unlock_doors = 1'b1;
    cyc(4);
    chk("open_again", door_locked, 0);
    accelerate_car = 1'b1;
    cyc(1);
    chk("accel_locks", door_locked, 1);
    chk("accel_tick", car_speed, 2);

    // Ramp to 100, then reset mid-ramp
    unlock_doors = 1'b0;
    cyc(196);
    chk("speed_100", car_speed, 100);
    rst = 1'b1;
    cyc(1);
    chk("midramp_rst_speed", car_speed, 0);
    chk("midramp_rst_locked", door_locked, 1);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_no_tick", car_speed, 0);
    cyc(1);
    chk("post_rst_tick", car_speed, 2);

    // Reset mid-WAIT
    accelerate_car = 1'b0;
    cyc(4);
    chk("back_to_0", car_speed, 0);
    unlock_doors = 1'b1;
    cyc(2);
    rst = 1'b1;
    cyc(1);
    chk("midwait_rst_locked", door_locked, 1);
    rst = 1'b0;
    cyc(3);
    chk("post_rst_dwell", door_locked, 1);
    cyc(1);
    chk("post_rst_open", door_locked, 0);

    unlock_doors = 1'b0;
    cyc(2);
    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running want finished");
    $fatal(1, "timeout");
  end

endmodule
